// File: rtl/aes128_round_seq_pkg.sv
// Shared types and pure-wiring helpers for the iterative AES-128 round sequencer.
// Provides:
//   state_t / byte_t  128-bit state and byte types; bit 0 is the MSB
//   NB_BYTES          bytes per AES block
//   transpose()       swaps FIPS column-major byte order and row-major order
//   shift_rows()      AES ShiftRows on the row-major layout
//   seq_state_e       sequencer FSM encoding
package aes_pkg;

  localparam int NB_BYTES = 16;

  typedef logic [0:127] state_t;
  typedef logic [0:7]   byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  // FIPS byte k = 4c+r lands at row r, column c. The mapping is its own inverse.
  function automatic state_t transpose(input state_t x);
    state_t y;
    y = '0;
    for (int k = 0; k < NB_BYTES; k++) begin
      y[32*(k%4) + 8*(k/4) +: 8] = x[8*k +: 8];
    end
    return y;
  endfunction

  // Row r rotates left by r bytes: output column c takes input column (c+r) mod 4.
  function automatic state_t shift_rows(input state_t x);
    state_t y;
    y = '0;
    for (int k = 0; k < NB_BYTES; k++) begin
      y[8*k +: 8] = x[32*(k/4) + 8*(((k%4) + (k/4)) % 4) +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/aes128_round_seq_mixcol.sv
// Combinational AES MixColumns on the row-major state.
// Ports:
//   din   in  128  row-major state (row r = bits [32r+:32])
//   dout  out 128  row-major state after MixColumns
module aes128_round_seq_mixcol
  import aes_pkg::*;
(
  input  state_t din,
  output state_t dout
);

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic byte_t xt(input byte_t b);
    return {b[1:7], 1'b0} ^ (b[0] ? 8'h1b : 8'h00);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    byte_t a0, a1, a2, a3;

    assign a0 = din[     8*c +: 8];
    assign a1 = din[32 + 8*c +: 8];
    assign a2 = din[64 + 8*c +: 8];
    assign a3 = din[96 + 8*c +: 8];

    assign dout[     8*c +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign dout[32 + 8*c +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign dout[64 + 8*c +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign dout[96 + 8*c +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

endmodule

// File: rtl/aes128_round_seq.sv
// Iterative AES-128 encryption sequencer: one full round per clock.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     plaintext handshake, in_data in FIPS byte order
//   out_valid/out_ready   ciphertext handshake, out_data in FIPS byte order
//   rk_idx / rk_data      round-key request and same-cycle key return
//   sb_in / sb_out        row-major state to/from the external S-box bank
//   busy                  high while rounds are being computed
//
// state | meaning
// IDLE  | waiting for plaintext, round-key 0 presented for the initial AddRoundKey
// ROUND | one cipher round per cycle, rnd = 1..NR
// DONE  | ciphertext presented and held until out_ready
module aes128_round_seq
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  state_t        in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output state_t        out_data,
  output logic [RW-1:0] rk_idx,
  input  state_t        rk_data,
  output state_t        sb_in,
  input  state_t        sb_out,
  output logic          busy
);

  localparam logic [RW-1:0] LAST = RW'(NR);

  seq_state_e    fsm, fsm_nxt;
  logic [RW-1:0] rnd, rnd_nxt;
  state_t        st, st_nxt;
  logic          load;

  state_t sr_out, mc_out, rk_t, round_res, load_val;

  assign rk_t     = transpose(rk_data);
  assign load_val = transpose(in_data) ^ rk_t;
  assign sr_out   = shift_rows(sb_out);

  aes128_round_seq_mixcol u_mixcol (
    .din  (sr_out),
    .dout (mc_out)
  );

  // The final round skips MixColumns.
  assign round_res = (rnd == LAST) ? (sr_out ^ rk_t) : (mc_out ^ rk_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      rnd <= '0;
      st  <= '0;
    end else begin
      fsm <= fsm_nxt;
      rnd <= rnd_nxt;
      st  <= st_nxt;
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    rnd_nxt = rnd;
    st_nxt  = st;
    load    = 1'b0;
    case (fsm)
      IDLE: begin
        load = in_valid;
      end
      ROUND: begin
        st_nxt  = round_res;
        rnd_nxt = rnd + RW'(1);
        if (rnd == LAST) begin
          fsm_nxt = DONE;
          rnd_nxt = '0;
        end
      end
      DONE: begin
        // Accepting in the same cycle as the unload keeps back-to-back blocks bubble-free.
        if (out_ready) begin
          if (in_valid) begin
            load = 1'b1;
          end else begin
            fsm_nxt = IDLE;
          end
        end
      end
      default: begin
        fsm_nxt = IDLE;
      end
    endcase
    if (load) begin
      st_nxt  = load_val;
      rnd_nxt = RW'(1);
      fsm_nxt = ROUND;
    end
  end

  // Every output is forced quiet during reset so an aborted block never leaks out.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    rk_idx    = '0;
    sb_in     = '0;
    if (!rst) begin
      case (fsm)
        IDLE: begin
          in_ready = 1'b1;
        end
        ROUND: begin
          busy   = 1'b1;
          rk_idx = rnd;
          sb_in  = st;
        end
        DONE: begin
          out_valid = 1'b1;
          out_data  = transpose(st);
          in_ready  = out_ready;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes128_round_seq.md
Name: aes128_round_seq

Overview:
- Iterative AES-128 encryption sequencer. Owns the 128-bit state register and steps it through one full round per clock: SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Reuses the team's combinational MixColumns block on the row-major state.
- SubBytes is an external combinational S-box bank. Round keys come from an external key store indexed by round number.
- Sits between the host stream interface (valid/ready) and the round datapath. Its output is the only path that produces ciphertext.

Parameters:
- NR, 10, number of rounds; the final round omits MixColumns. Legal range 2..14.
- RW, 4, width of round index; must satisfy 2**RW > NR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext present.
- in_ready  out  1  sequencer can accept plaintext this cycle.
- in_data  in  128  plaintext, FIPS-197 byte order; byte k = bits [8k+:8], bit 0 = MSB.
- out_valid  out  1  ciphertext present.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext, FIPS-197 byte order.
- rk_idx  out  RW  round-key index requested this cycle.
- rk_data  in  128  round key rk_idx, FIPS byte order, combinational same-cycle return.
- sb_in  out  128  state to external S-box bank, row-major.
- sb_out  in  128  S-box bank result, combinational, row-major.
- busy  out  1  high in ROUND state.

Behaviour:
- Internal state layout is row-major: row r = bits [32r+:32]; column c byte at [32r+8c+:8].
  - Load and unload use transpose T(x): FIPS byte 4c+r maps to row r, column c. T is self-inverse.
  - Round keys pass through T before the XOR.
- ShiftRows is pure wiring: row r rotates left by r bytes. Row 0 is unchanged; row 1 maps byte c to c+1 mod 4.
- FSM states: IDLE, ROUND, DONE.
  - IDLE: in_ready=1, rk_idx=0. On in_valid: state <= T(in_data) ^ T(rk_data), rnd <= 1, go to ROUND.
  - ROUND: rk_idx=rnd, sb_in=state.
    - rnd<NR: state <= MixColumns(ShiftRows(sb_out)) ^ T(rk_data).
    - rnd==NR: state <= ShiftRows(sb_out) ^ T(rk_data), go to DONE.
    - rnd increments every cycle; in_valid is ignored.
  - DONE: out_valid=1, out_data=T(state), held stable until out_ready.
    - out_ready & !in_valid: go to IDLE.
    - out_ready & in_valid: accept the new block in the same cycle (load as in IDLE) and go to ROUND.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A combinational path from out_ready to in_ready is required.
- Latency: accept at edge T; out_valid first high in cycle T+NR+1. Throughput is one block per NR+1 cycles with zero bubbles when out_ready is held high.
- Backpressure: DONE persists indefinitely; out_data, state and rk_idx do not change.
- Reset values: FSM=IDLE, rnd=0, state=0, out_valid=0, out_data=0, busy=0, in_ready=1 in the first post-reset cycle. rk_idx=0 and sb_in=0 while in reset.
- Reset mid-ROUND or mid-DONE aborts the block without emitting it. No partial output is ever visible.
- rk_idx never exceeds NR. sb_in is 0 outside ROUND, so the S-box bank sees no spurious toggling.

Decomposition:
- Package aes_pkg holds:
  - typedef state_t = logic[0:127]; byte_t = logic[0:7].
  - Constant NB_BYTES=16.
  - Functions transpose() and shift_rows(), pure wiring.
  - FSM enum seq_state_e {IDLE, ROUND, DONE}.
- One sub-module instance: the existing MixColumns (message/crypte), driven by shift_rows(sb_out).
- Sequencer RTL is FSM, round counter and state register; no other sub-modules.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Bench supplies rk0..rk10 and a behavioural S-box.
  - Requires out_data=3925841d02dc09fbdc118597196a0b32 at cycle T+11.
  - rk_idx sequence 0,1,...,10.
- FIPS-197 App. C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: out_ready=0 for 20 cycles after out_valid.
  - out_data stays constant and in_ready=0.
  - Releasing out_ready gives one transfer, then IDLE.
- Back-to-back: three blocks with in_valid and out_ready held high.
  - Accepts land at T, T+11, T+22; no idle cycle between blocks.
  - All three ciphertexts match the reference model.
- Reset at rnd=5 with in_valid=0: next cycle out_valid=0, state=0, in_ready=1, and no ciphertext is ever emitted.
  - A following new block encrypts correctly.
- NR=2 build: known 2-round vector matches the model, and out_valid appears at T+3.
